icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//   Direct-mapped instruction cache; responder end of the fetcher's icache_enable/pc -> icache_valid/icache_inst handshake.
//   Hits answer combinationally in the same cycle; misses refill one line from the memory controller, one 32-bit beat at a time.
//   Sits between the instruction fetcher and the memory controller.
// PARAMETERS
//   INDEX_BITS   6   line index width; 2**INDEX_BITS lines
//   OFFSET_BITS  4   byte-offset width; line = 2**OFFSET_BITS bytes, LINE_WORDS = 2**(OFFSET_BITS-2) (min 2)
// PORTS
//   clk             in   1   clock, posedge
//   rst             in   1   asynchronous active-high reset
//   rdy             in   1   global ready; low freezes all state
//   icache_enable   in   1   fetcher requests instruction at pc_to_icache
//   pc_to_icache    in   32  fetch address; bits[1:0] ignored
//   icache_valid    out  1   icache_inst is valid for pc_to_icache this cycle
//   icache_inst     out  32  instruction word
//   mem_req         out  1   line refill request, held high for the whole refill
//   mem_addr        out  32  line base address, stable while mem_req high
//   mem_data_valid  in   1   one refill beat present this cycle
//   mem_data        in   32  beat data; beat k = word at mem_addr+4k
// BEHAVIOUR
//   Address split: tag = pc[31:INDEX_BITS+OFFSET_BITS], index = pc[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS], word = pc[OFFSET_BITS-1:2].
//   Storage: valid bit + tag per line; data array [line][word]. No reset is applied to the tag or data arrays.
//   States: IDLE, REFILL. The state register is 1 bit plus a beat counter of OFFSET_BITS-2 bits.
//   Hit = valid[index] && tag match.
//   icache_valid = rdy && icache_enable && state==IDLE && hit, purely combinational.
//     icache_inst = data[index][word], combinational; don't-care when icache_valid=0.
//   IDLE: on a clock edge with rdy && icache_enable && !hit:
//     latch line base {pc[31:OFFSET_BITS], 0} into mem_addr;
//     clear valid[index];
//     zero the beat counter;
//     go to REFILL.
//   REFILL: mem_req=1. Each edge with rdy && mem_data_valid:
//     write mem_data into data[line][counter];
//     increment the counter.
//     On the beat where counter == LINE_WORDS-1: set valid, write tag, return to IDLE. mem_req is low from the next cycle.
//   Miss latency: request at cycle n -> mem_req high at n+1. The hit appears in the cycle after the last beat's edge, provided pc is unchanged.
//   During REFILL, icache_valid=0 for every pc, including pcs that would hit other lines.
//   icache_enable falling or pc changing mid-refill (fetcher redirect): the refill still completes and the line is installed. There is no abort.
//   rdy low: no state or array update, icache_valid=0, mem_req/mem_addr hold. The memory controller must not send beats while rdy is low.
//   The memory controller must send exactly LINE_WORDS beats per request, in order. Extra beats in IDLE are ignored.
//   Reset (async, any time including mid-refill):
//     all valid bits=0, state=IDLE, counter=0, mem_addr=0;
//     mem_req=0 and icache_valid=0 immediately.
// TESTING (INDEX_BITS=6, OFFSET_BITS=4)
//   Reset: assert rst, then release; enable=1, pc=0x0 -> icache_valid=0; the next cycle mem_req=1, mem_addr=0x0.
//   Cold miss: pc=0x1004; beats 0xA0,0xA1,0xA2,0xA3 with a 2-cycle gap each -> mem_req drops after the 4th beat; the following cycle icache_valid=1, icache_inst=0xA1.
//   Hit sweep: pc 0x1000,0x1004,0x1008,0x100C on consecutive cycles -> valid each cycle, inst 0xA0..0xA3, mem_req stays 0.
//   Conflict: pc=0x1400 (index 0, new tag) -> refill with 0xB0..0xB3, inst=0xB0. Then pc=0x1000 -> misses again with mem_addr=0x1000.
//   rdy stall: rdy=0 for 5 cycles after beat 2 of a refill -> counter holds, valid=0; after resume, 2 more beats complete the line correctly.
//   Reset mid-refill: rst pulse after beat 1 -> mem_req=0 asynchronously; pc=0x1000 then misses with mem_addr=0x1000.

Source files
------------

// File: rtl/icache.sv
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped instruction cache. Hits answer combinationally;
//                misses refill one line from memory, one 32-bit beat at a time.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        icache_enable,
    input  logic [31:0] pc_to_icache,
    output logic        icache_valid,
    output logic [31:0] icache_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [31:0] mem_data
);

    localparam int LINES      = 2 ** INDEX_BITS;
    localparam int LINE_WORDS = 2 ** (OFFSET_BITS - 2);
    localparam int CNT_W      = OFFSET_BITS - 2;
    localparam int TAG_W      = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_W     = 32 - OFFSET_BITS;
    localparam int DATA_DEPTH = LINES * LINE_WORDS;

    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [LINE_W-1:0]      r_line_addr;
    logic                   r_mem_req;
    logic [LINES-1:0]       r_valid;

    logic [TAG_W-1:0]       r_tag  [LINES];
    logic [31:0]            r_data [DATA_DEPTH];

    logic [TAG_W-1:0]       w_tag;
    logic [INDEX_BITS-1:0]  w_index;
    logic [CNT_W-1:0]       w_word;
    logic                   w_hit;
    logic [INDEX_BITS-1:0]  w_fill_index;
    logic [TAG_W-1:0]       w_fill_tag;
    logic                   w_beat;
    logic                   w_last_beat;
    logic                   w_unused;

    assign w_tag   = pc_to_icache[31:INDEX_BITS+OFFSET_BITS];
    assign w_index = pc_to_icache[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign w_word  = pc_to_icache[OFFSET_BITS-1:2];
    assign w_unused = &{1'b0, pc_to_icache[1:0]};

    // Refill targets the latched line, not the live pc, so redirects are harmless.
    assign w_fill_index = r_line_addr[INDEX_BITS-1:0];
    assign w_fill_tag   = r_line_addr[LINE_W-1:INDEX_BITS];

    assign w_beat      = rdy && (r_state == S_REFILL) && mem_data_valid;
    assign w_last_beat = w_beat && (r_cnt == C_LAST_BEAT);

    assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

    assign icache_valid = rdy && icache_enable && (r_state == S_IDLE) && w_hit;
    assign icache_inst  = r_data[{w_index, w_word}];
    assign mem_req      = r_mem_req;
    assign mem_addr     = {r_line_addr, {OFFSET_BITS{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_line_addr <= '0;
            r_mem_req   <= 1'b0;
            r_valid     <= '0;
        end else if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (icache_enable && !w_hit) begin
                        r_line_addr      <= pc_to_icache[31:OFFSET_BITS];
                        r_valid[w_index] <= 1'b0;
                        r_cnt            <= '0;
                        r_mem_req        <= 1'b1;
                        r_state          <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_data_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST_BEAT) begin
                            r_valid[w_fill_index] <= 1'b1;
                            r_mem_req             <= 1'b0;
                            r_state               <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_data[{w_fill_index, r_cnt}] <= mem_data;
        end
        if (w_last_beat) begin
            r_tag[w_fill_index] <= w_fill_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
//  Module      : tb_icache
//  Description : Directed self-checking bench for icache (INDEX_BITS=6, OFFSET_BITS=4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        icache_enable;
    logic [31:0] pc_to_icache;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_data_valid;
    logic [31:0] mem_data;

    int n_checks = 0;
    int n_pass   = 0;

    icache #(
        .INDEX_BITS  (6),
        .OFFSET_BITS (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .icache_enable  (icache_enable),
        .pc_to_icache   (pc_to_icache),
        .icache_valid   (icache_valid),
        .icache_inst    (icache_inst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        mem_data       = d;
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        mem_data       = '0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] exp_inst);
        pc_to_icache = pc;
        #1;
        check({tag, ".valid"}, {31'b0, icache_valid}, 32'd1);
        check({tag, ".inst"},  icache_inst,           exp_inst);
        check({tag, ".req"},   {31'b0, mem_req},      32'd0);
        step();
    endtask

    initial begin
        rst            = 1'b1;
        rdy            = 1'b1;
        icache_enable  = 1'b0;
        pc_to_icache   = '0;
        mem_data_valid = 1'b0;
        mem_data       = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state and first miss at pc 0
        icache_enable = 1'b1;
        pc_to_icache  = 32'h0;
        #1;
        check("rst.valid", {31'b0, icache_valid}, 32'd0);
        check("rst.req",   {31'b0, mem_req},      32'd0);
        check("rst.addr",  mem_addr,              32'h0);
        step();
        check("miss0.req",  {31'b0, mem_req}, 32'd1);
        check("miss0.addr", mem_addr,         32'h0);
        for (int i = 0; i < 4; i++) beat(32'h10 + i);
        check("miss0.done", {31'b0, mem_req},      32'd0);
        check("miss0.hit",  {31'b0, icache_valid}, 32'd1);
        check("miss0.inst", icache_inst,           32'h10);

        // Cold miss with gapped beats; 0x1004 conflicts with line 0
        pc_to_icache = 32'h1004;
        #1;
        check("cold.miss", {31'b0, icache_valid}, 32'd0);
        step();
        check("cold.req",  {31'b0, mem_req}, 32'd1);
        check("cold.addr", mem_addr,         32'h1000);
        for (int i = 0; i < 4; i++) begin
            step();
            step();
            check("cold.gap_valid", {31'b0, icache_valid}, 32'd0);
            beat(32'hA0 + i);
        end
        check("cold.req_drop", {31'b0, mem_req},      32'd0);
        check("cold.hit",      {31'b0, icache_valid}, 32'd1);
        check("cold.inst",     icache_inst,           32'hA1);

        // Hit sweep
        for (int i = 0; i < 4; i++) look("sweep", 32'h1000 + 4 * i, 32'hA0 + i);

        // Conflict eviction and return
        pc_to_icache = 32'h1400;
        step();
        check("conf.req",  {31'b0, mem_req}, 32'd1);
        check("conf.addr", mem_addr,         32'h1400);
        for (int i = 0; i < 4; i++) beat(32'hB0 + i);
        look("conf.b", 32'h1400, 32'hB0);
        pc_to_icache = 32'h1000;
        #1;
        check("conf.back_miss", {31'b0, icache_valid}, 32'd0);
        step();
        check("conf.back_addr", mem_addr, 32'h1000);
        for (int i = 0; i < 4; i++) beat(32'hA0 + i);
        look("conf.a", 32'h1000, 32'hA0);

        // rdy low in IDLE blocks a hit
        rdy = 1'b0;
        #1;
        check("rdy0.hit_blocked", {31'b0, icache_valid}, 32'd0);
        rdy = 1'b1;

        // rdy stall mid-refill with a redirect to a pc that would hit line 0
        pc_to_icache = 32'h2018;
        step();
        check("stall.addr", mem_addr, 32'h2010);
        beat(32'hC0);
        beat(32'hC1);
        rdy          = 1'b0;
        pc_to_icache = 32'h1000;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall.valid", {31'b0, icache_valid}, 32'd0);
            check("stall.req",   {31'b0, mem_req},      32'd1);
            check("stall.addr_hold", mem_addr,          32'h2010);
        end
        rdy = 1'b1;
        #1;
        check("refill.other_line", {31'b0, icache_valid}, 32'd0);
        beat(32'hC2);
        beat(32'hC3);
        look("stall.w2", 32'h2018, 32'hC2);
        look("stall.w1", 32'h2014, 32'hC1);
        look("stall.w3", 32'h201C, 32'hC3);
        look("stall.line0", 32'h1000, 32'hA0);

        // Stray beat in IDLE is ignored
        beat(32'hDEAD);
        look("stray", 32'h1000, 32'hA0);

        // Asynchronous reset mid-refill
        pc_to_icache = 32'h3000;
        step();
        check("rstm.req", {31'b0, mem_req}, 32'd1);
        beat(32'hD0);
        #2;
        rst = 1'b1;
        #1;
        check("rstm.req_async",  {31'b0, mem_req},      32'd0);
        check("rstm.valid",      {31'b0, icache_valid}, 32'd0);
        check("rstm.addr",       mem_addr,              32'h0);
        step();
        rst          = 1'b0;
        pc_to_icache = 32'h1000;
        #1;
        check("rstm.line0_gone", {31'b0, icache_valid}, 32'd0);
        step();
        check("rstm.req2",  {31'b0, mem_req}, 32'd1);
        check("rstm.addr2", mem_addr,         32'h1000);
        for (int i = 0; i < 4; i++) beat(32'hE0 + i);
        look("rstm.hit", 32'h100C, 32'hE3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
